// File: rtl/ecc_read_checker.sv
// ecc_read_checker: SEC-DED (extended Hamming) read-path checker with scrub write-back request and saturating counters.
// Latency 2 cycles, one word per cycle; the data path never stalls, and a new SEC that finds the scrub slot busy is dropped.
module ecc_read_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int CNT_WIDTH  = 8,
    // Smallest P with 2^P >= DATA_WIDTH + P + 1
    localparam int P  = (4   >= DATA_WIDTH + 3) ? 2 :
                        (8   >= DATA_WIDTH + 4) ? 3 :
                        (16  >= DATA_WIDTH + 5) ? 4 :
                        (32  >= DATA_WIDTH + 6) ? 5 :
                        (64  >= DATA_WIDTH + 7) ? 6 :
                        (128 >= DATA_WIDTH + 8) ? 7 : 8,
    localparam int CW = DATA_WIDTH + P + 1,
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [AW-1:0]         i_addr,
    input  logic [CW-1:0]         i_codeword,
    output logic                  o_valid,
    output logic [AW-1:0]         o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_sec,
    output logic                  o_ded,
    output logic                  o_scrub_req,
    input  logic                  i_scrub_ack,
    output logic [AW-1:0]         o_scrub_addr,
    output logic [CW-1:0]         o_scrub_codeword,
    output logic                  o_scrub_drop,
    input  logic                  i_clr_counts,
    output logic [CNT_WIDTH-1:0]  o_sec_count,
    output logic [CNT_WIDTH-1:0]  o_ded_count
);

    typedef enum logic {SCRUB_IDLE, SCRUB_PEND} scrub_state_t;

    function automatic logic [P-1:0] calc_syndrome(input logic [CW-1:0] cw);
        logic [P-1:0] s;
        s = '0;
        for (int i = 1; i < CW; i++) begin
            if (cw[i]) s = s ^ P'(i);
        end
        return s;
    endfunction

    // Data bits live at the non-power-of-two positions, in ascending order.
    function automatic logic [DATA_WIDTH-1:0] extract_data(input logic [CW-1:0] cw);
        logic [DATA_WIDTH-1:0] d;
        int k;
        d = '0;
        k = 0;
        for (int i = 1; i < CW; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[k] = cw[i];
                k++;
            end
        end
        return d;
    endfunction

    // Stage 1 registers
    logic                  s1_vld_q;
    logic [AW-1:0]         s1_addr_q;
    logic [CW-1:0]         s1_cw_q;
    logic [P-1:0]          s1_syn_q;
    logic                  s1_par_q;

    // Stage 2 / output registers
    logic                  out_vld_q;
    logic [AW-1:0]         out_addr_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_sec_q;
    logic                  out_ded_q;

    scrub_state_t          scrub_state_q, scrub_state_d;
    logic [AW-1:0]         scrub_addr_q, scrub_addr_d;
    logic [CW-1:0]         scrub_cw_q, scrub_cw_d;
    logic                  scrub_drop_q, scrub_drop_d;

    logic [CNT_WIDTH-1:0]  sec_cnt_q, sec_cnt_d;
    logic [CNT_WIDTH-1:0]  ded_cnt_q, ded_cnt_d;

    logic                  dec_sec;
    logic                  dec_ded;
    logic [CW-1:0]         corr_cw;
    logic                  sec_evt;
    logic                  ded_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_cw_q   <= '0;
            s1_syn_q  <= '0;
            s1_par_q  <= 1'b0;
        end else begin
            s1_vld_q <= i_valid;
            if (i_valid) begin
                s1_addr_q <= i_addr;
                s1_cw_q   <= i_codeword;
                s1_syn_q  <= calc_syndrome(i_codeword);
                s1_par_q  <= ^i_codeword;
            end
        end
    end

    // S=0 with odd parity flips bit 0, so one shift covers every correctable case.
    always_comb begin
        dec_sec = s1_par_q && (int'(s1_syn_q) <= CW - 1);
        dec_ded = !dec_sec && ((s1_syn_q != '0) || s1_par_q);
        corr_cw = s1_cw_q ^ (CW'(dec_sec) << s1_syn_q);
        sec_evt = s1_vld_q && dec_sec;
        ded_evt = s1_vld_q && dec_ded;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_sec_q  <= 1'b0;
            out_ded_q  <= 1'b0;
        end else begin
            out_vld_q <= s1_vld_q;
            out_sec_q <= sec_evt;
            out_ded_q <= ded_evt;
            if (s1_vld_q) begin
                out_addr_q <= s1_addr_q;
                out_data_q <= extract_data(corr_cw);
            end
        end
    end

    always_comb begin
        scrub_state_d = scrub_state_q;
        scrub_addr_d  = scrub_addr_q;
        scrub_cw_d    = scrub_cw_q;
        scrub_drop_d  = 1'b0;
        case (scrub_state_q)
            SCRUB_IDLE: begin
                if (sec_evt) begin
                    scrub_state_d = SCRUB_PEND;
                    scrub_addr_d  = s1_addr_q;
                    scrub_cw_d    = corr_cw;
                end
            end
            SCRUB_PEND: begin
                if (i_scrub_ack) begin
                    if (sec_evt) begin
                        scrub_addr_d = s1_addr_q;
                        scrub_cw_d   = corr_cw;
                    end else begin
                        scrub_state_d = SCRUB_IDLE;
                    end
                end else if (sec_evt) begin
                    scrub_drop_d = 1'b1;
                end
            end
            default: scrub_state_d = SCRUB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scrub_state_q <= SCRUB_IDLE;
            scrub_addr_q  <= '0;
            scrub_cw_q    <= '0;
            scrub_drop_q  <= 1'b0;
        end else begin
            scrub_state_q <= scrub_state_d;
            scrub_addr_q  <= scrub_addr_d;
            scrub_cw_q    <= scrub_cw_d;
            scrub_drop_q  <= scrub_drop_d;
        end
    end

    // Clear takes priority over a coincident increment.
    always_comb begin
        sec_cnt_d = sec_cnt_q;
        ded_cnt_d = ded_cnt_q;
        if (i_clr_counts) begin
            sec_cnt_d = '0;
            ded_cnt_d = '0;
        end else begin
            if (sec_evt && (sec_cnt_q != {CNT_WIDTH{1'b1}})) sec_cnt_d = sec_cnt_q + 1'b1;
            if (ded_evt && (ded_cnt_q != {CNT_WIDTH{1'b1}})) ded_cnt_d = ded_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else begin
            sec_cnt_q <= sec_cnt_d;
            ded_cnt_q <= ded_cnt_d;
        end
    end

    assign o_valid          = out_vld_q;
    assign o_addr           = out_addr_q;
    assign o_data           = out_data_q;
    assign o_sec            = out_sec_q;
    assign o_ded            = out_ded_q;
    assign o_scrub_req      = (scrub_state_q == SCRUB_PEND);
    assign o_scrub_addr     = scrub_addr_q;
    assign o_scrub_codeword = scrub_cw_q;
    assign o_scrub_drop     = scrub_drop_q;
    assign o_sec_count      = sec_cnt_q;
    assign o_ded_count      = ded_cnt_q;

endmodule

// File: tb/tb_ecc_read_checker.sv
// Directed bench for ecc_read_checker: a table of single-word vectors plus hand-written scrub, counter and reset sequences.
module tb_ecc_read_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic [3:0]  i_addr;
    logic [12:0] i_codeword;
    logic        o_valid;
    logic [3:0]  o_addr;
    logic [7:0]  o_data;
    logic        o_sec;
    logic        o_ded;
    logic        o_scrub_req;
    logic        i_scrub_ack;
    logic [3:0]  o_scrub_addr;
    logic [12:0] o_scrub_codeword;
    logic        o_scrub_drop;
    logic        i_clr_counts;
    logic [7:0]  o_sec_count;
    logic [7:0]  o_ded_count;

    always #5 clk = ~clk;

    ecc_read_checker dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_valid          (i_valid),
        .i_addr           (i_addr),
        .i_codeword       (i_codeword),
        .o_valid          (o_valid),
        .o_addr           (o_addr),
        .o_data           (o_data),
        .o_sec            (o_sec),
        .o_ded            (o_ded),
        .o_scrub_req      (o_scrub_req),
        .i_scrub_ack      (i_scrub_ack),
        .o_scrub_addr     (o_scrub_addr),
        .o_scrub_codeword (o_scrub_codeword),
        .o_scrub_drop     (o_scrub_drop),
        .i_clr_counts     (i_clr_counts),
        .o_sec_count      (o_sec_count),
        .o_ded_count      (o_ded_count)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [12:0] cw;
        logic [7:0]  data;
        logic        sec;
        logic        ded;
        logic [12:0] scrub_cw;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vt [NVEC];

    int n_vec = 0;
    int n_err = 0;
    int exp_sec = 0;
    int exp_ded = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic ack_scrub();
        i_scrub_ack = 1'b1;
        step();
        i_scrub_ack = 1'b0;
    endtask

    initial begin
        // addr, codeword, data, sec, ded, scrub codeword
        vt[0] = '{4'd3,  13'h144E, 8'hA5, 1'b0, 1'b0, 13'h0000}; // clean
        vt[1] = '{4'd5,  13'h140E, 8'hA5, 1'b1, 1'b0, 13'h144E}; // data bit 6 flipped
        vt[2] = '{4'd6,  13'h144F, 8'hA5, 1'b1, 1'b0, 13'h144E}; // overall parity bit
        vt[3] = '{4'd7,  13'h100E, 8'h81, 1'b0, 1'b1, 13'h0000}; // bits 6,10: S=12, p=0
        vt[4] = '{4'd9,  13'h155C, 8'hA5, 1'b0, 1'b1, 13'h0000}; // 3 errors, S=13 out of range
        vt[5] = '{4'd10, 13'h1556, 8'hA4, 1'b0, 1'b1, 13'h0000}; // 3 errors, S=15
        vt[6] = '{4'd11, 13'h0000, 8'h00, 1'b0, 1'b0, 13'h0000}; // all-zero clean
        vt[7] = '{4'd12, 13'h1000, 8'h00, 1'b1, 1'b0, 13'h0000}; // top position, S=12
        vt[8] = '{4'd13, 13'h1FFF, 8'h7F, 1'b1, 1'b0, 13'h0FFF}; // all ones -> flip bit 12
        vt[9] = '{4'd14, 13'h1448, 8'hA5, 1'b0, 1'b1, 13'h0000}; // bits 1,2: S=3, p=0

        rst_n        = 1'b0;
        i_valid      = 1'b0;
        i_addr       = '0;
        i_codeword   = '0;
        i_scrub_ack  = 1'b0;
        i_clr_counts = 1'b0;
        step();
        step();
        check("reset o_valid",     32'(o_valid), 32'd0);
        check("reset o_scrub_req", 32'(o_scrub_req), 32'd0);
        check("reset o_data",      32'(o_data), 32'd0);
        check("reset o_sec_count", 32'(o_sec_count), 32'd0);
        check("reset o_ded_count", 32'(o_ded_count), 32'd0);
        rst_n = 1'b1;
        step();

        // Table: one isolated word at a time, latency 2
        for (int v = 0; v < NVEC; v++) begin
            i_valid    = 1'b1;
            i_addr     = vt[v].addr;
            i_codeword = vt[v].cw;
            step();
            i_valid = 1'b0;
            check("latency o_valid early", 32'(o_valid), 32'd0);
            step();
            if (vt[v].sec) exp_sec = sat(exp_sec + 1);
            if (vt[v].ded) exp_ded = sat(exp_ded + 1);
            check("o_valid",     32'(o_valid), 32'd1);
            check("o_addr",      32'(o_addr), 32'(vt[v].addr));
            check("o_data",      32'(o_data), 32'(vt[v].data));
            check("o_sec",       32'(o_sec), 32'(vt[v].sec));
            check("o_ded",       32'(o_ded), 32'(vt[v].ded));
            check("o_sec_count", 32'(o_sec_count), 32'(exp_sec));
            check("o_ded_count", 32'(o_ded_count), 32'(exp_ded));
            check("o_scrub_req", 32'(o_scrub_req), 32'(vt[v].sec));
            if (vt[v].sec) begin
                check("o_scrub_addr",     32'(o_scrub_addr), 32'(vt[v].addr));
                check("o_scrub_codeword", 32'(o_scrub_codeword), 32'(vt[v].scrub_cw));
                ack_scrub();
                check("scrub req after ack", 32'(o_scrub_req), 32'd0);
            end
            step();
            check("o_valid idle", 32'(o_valid), 32'd0);
            check("o_sec idle",   32'(o_sec), 32'd0);
        end

        // Back-to-back SEC, no ack: first request held, one drop pulse
        i_valid = 1'b1; i_addr = 4'd1; i_codeword = 13'h140E;
        step();
        i_addr = 4'd2; i_codeword = 13'h144F;
        step();
        i_valid = 1'b0;
        check("contend req",  32'(o_scrub_req), 32'd1);
        check("contend addr", 32'(o_scrub_addr), 32'd1);
        check("contend drop early", 32'(o_scrub_drop), 32'd0);
        step();
        check("contend drop pulse", 32'(o_scrub_drop), 32'd1);
        check("contend addr held",  32'(o_scrub_addr), 32'd1);
        step();
        check("contend drop end",   32'(o_scrub_drop), 32'd0);
        check("contend req held",   32'(o_scrub_req), 32'd1);
        exp_sec = sat(exp_sec + 2);
        check("contend sec_count",  32'(o_sec_count), 32'(exp_sec));
        ack_scrub();
        check("contend req cleared", 32'(o_scrub_req), 32'd0);

        // Back-to-back SEC with ack on the second SEC edge: reload, no drop
        i_valid = 1'b1; i_addr = 4'd4; i_codeword = 13'h140E;
        step();
        i_addr = 4'd8; i_codeword = 13'h1000;
        step();
        i_valid = 1'b0;
        check("reload first addr", 32'(o_scrub_addr), 32'd4);
        i_scrub_ack = 1'b1;
        step();
        i_scrub_ack = 1'b0;
        check("reload req",  32'(o_scrub_req), 32'd1);
        check("reload addr", 32'(o_scrub_addr), 32'd8);
        check("reload cw",   32'(o_scrub_codeword), 32'h0000);
        check("reload no drop", 32'(o_scrub_drop), 32'd0);
        step();
        check("reload req held", 32'(o_scrub_req), 32'd1);
        check("reload no drop 2", 32'(o_scrub_drop), 32'd0);
        exp_sec = sat(exp_sec + 2);
        ack_scrub();

        // 300 consecutive SEC words: counter saturates
        i_valid = 1'b1; i_addr = 4'd15; i_codeword = 13'h140E;
        for (int c = 0; c < 300; c++) step();
        i_valid = 1'b0;
        step();
        step();
        exp_sec = sat(exp_sec + 300);
        check("sec_count saturated", 32'(o_sec_count), 32'd255);
        check("sec_count model",     32'(o_sec_count), 32'(exp_sec));
        check("ded_count unchanged", 32'(o_ded_count), 32'(exp_ded));
        ack_scrub();
        check("sat req cleared", 32'(o_scrub_req), 32'd0);

        // Clear coinciding with an SEC increment
        i_valid = 1'b1; i_addr = 4'd2; i_codeword = 13'h140E;
        step();
        i_valid = 1'b0;
        i_clr_counts = 1'b1;
        step();
        i_clr_counts = 1'b0;
        exp_sec = 0;
        exp_ded = 0;
        check("clr o_sec",       32'(o_sec), 32'd1);
        check("clr sec_count",   32'(o_sec_count), 32'(exp_sec));
        check("clr ded_count",   32'(o_ded_count), 32'(exp_ded));
        ack_scrub();
        i_valid = 1'b1; i_addr = 4'd7; i_codeword = 13'h100E;
        step();
        i_valid = 1'b0;
        step();
        exp_ded = 1;
        check("post-clr ded_count", 32'(o_ded_count), 32'(exp_ded));
        check("post-clr sec_count", 32'(o_sec_count), 32'(exp_sec));

        // Reset mid-stream with a pending scrub
        i_valid = 1'b1; i_addr = 4'd5; i_codeword = 13'h144F;
        step();
        step();
        step();
        check("pre-reset req", 32'(o_scrub_req), 32'd1);
        rst_n   = 1'b0;
        i_valid = 1'b0;
        #1;
        check("rst o_valid",     32'(o_valid), 32'd0);
        check("rst o_sec",       32'(o_sec), 32'd0);
        check("rst o_ded",       32'(o_ded), 32'd0);
        check("rst o_addr",      32'(o_addr), 32'd0);
        check("rst o_data",      32'(o_data), 32'd0);
        check("rst o_scrub_req", 32'(o_scrub_req), 32'd0);
        check("rst o_scrub_drop", 32'(o_scrub_drop), 32'd0);
        check("rst scrub_addr",  32'(o_scrub_addr), 32'd0);
        check("rst scrub_cw",    32'(o_scrub_codeword), 32'd0);
        check("rst sec_count",   32'(o_sec_count), 32'd0);
        check("rst ded_count",   32'(o_ded_count), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post-rst o_valid", 32'(o_valid), 32'd0);
        step();
        check("post-rst o_valid 2", 32'(o_valid), 32'd0);
        check("post-rst drop",      32'(o_scrub_drop), 32'd0);
        check("post-rst req",       32'(o_scrub_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
